// File: rtl/spi_reg_writer.sv
// SPI mode-0 initiator that sends one 16-bit register-write frame per start.
// Frame layout: write flag, 7-bit address, 8-bit data, MSB first.
module spi_reg_writer #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       sclk,
  output logic       copi,
  output logic       ncs
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0] cnt;
  logic [4:0]    edg;
  logic [15:0]   shreg;

  logic tick;
  logic accept;
  logic last_edge;
  logic shift_en;

  logic sclk_d, copi_d, ncs_d, busy_d, done_d;

  assign tick      = (cnt == CW'(CLK_DIV - 1));
  assign accept    = (state == IDLE) && start;
  assign last_edge = (edg == 5'd30);
  // Odd-numbered edges are falling; the final falling edge keeps bit0 on copi.
  assign shift_en  = (state == SHIFT) && tick && sclk && !last_edge;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start) state_nxt = SETUP;
      SETUP: if (tick) state_nxt = SHIFT;
      SHIFT: if (tick && last_edge) state_nxt = HOLD;
      HOLD:  if (tick) state_nxt = GAP;
      GAP:   if (tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sclk_d = 1'b0;
    copi_d = 1'b0;
    ncs_d  = 1'b1;
    busy_d = 1'b0;
    done_d = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          ncs_d  = 1'b0;
          busy_d = 1'b1;
          copi_d = 1'b1;
        end
      end
      SETUP: begin
        ncs_d  = 1'b0;
        busy_d = 1'b1;
        copi_d = copi;
        sclk_d = tick;
      end
      SHIFT: begin
        ncs_d  = 1'b0;
        busy_d = 1'b1;
        sclk_d = tick ? ~sclk : sclk;
        copi_d = shift_en ? shreg[14] : copi;
      end
      HOLD: begin
        ncs_d  = tick;
        busy_d = 1'b1;
        copi_d = tick ? 1'b0 : copi;
      end
      GAP: begin
        busy_d = !tick;
        done_d = tick;
      end
      default: begin
        ncs_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      edg   <= '0;
      shreg <= '0;
      sclk  <= 1'b0;
      copi  <= 1'b0;
      ncs   <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      sclk <= sclk_d;
      copi <= copi_d;
      ncs  <= ncs_d;
      busy <= busy_d;
      done <= done_d;

      if (state == IDLE || tick) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end

      if (state == SETUP && tick) begin
        edg <= '0;
      end else if (state == SHIFT && tick) begin
        edg <= edg + 5'd1;
      end

      if (accept) begin
        shreg <= {1'b1, addr, wdata};
      end else if (shift_en) begin
        shreg <= {shreg[14:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_writer.sv
// Directed bench for spi_reg_writer: three instances (T=4, 2, 7)
// with a bus monitor that decodes frames and checks mode-0 timing.
module tb_spi_reg_writer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] start = '0;
  logic [6:0] addr [3];
  logic [7:0] wdata [3];
  logic [2:0] busy, done, sclk, copi, ncs;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spi_reg_writer #(.CLK_DIV(4)) u4 (
    .clk(clk), .rst(rst), .start(start[0]),
    .addr(addr[0]), .wdata(wdata[0]),
    .busy(busy[0]), .done(done[0]), .sclk(sclk[0]),
    .copi(copi[0]), .ncs(ncs[0])
  );

  spi_reg_writer #(.CLK_DIV(2)) u2 (
    .clk(clk), .rst(rst), .start(start[1]),
    .addr(addr[1]), .wdata(wdata[1]),
    .busy(busy[1]), .done(done[1]), .sclk(sclk[1]),
    .copi(copi[1]), .ncs(ncs[1])
  );

  spi_reg_writer #(.CLK_DIV(7)) u7 (
    .clk(clk), .rst(rst), .start(start[2]),
    .addr(addr[2]), .wdata(wdata[2]),
    .busy(busy[2]), .done(done[2]), .sclk(sclk[2]),
    .copi(copi[2]), .ncs(ncs[2])
  );

  // Bus monitor state, one slot per instance
  logic [15:0] sh [3];
  logic [15:0] last_frame [3];
  int bits [3];
  int low_cnt [3];
  int high_cnt [3];
  int last_low [3];
  int last_high [3];
  int nframes [3];
  int partial [3];
  int dcount [3];
  int viol [3];
  logic prev_sclk [3];
  logic prev_copi [3];
  logic prev_ncs [3];

  initial begin
    for (int i = 0; i < 3; i++) begin
      sh[i] = '0; last_frame[i] = '0;
      bits[i] = 0; low_cnt[i] = 0; high_cnt[i] = 0;
      last_low[i] = 0; last_high[i] = 0;
      nframes[i] = 0; partial[i] = 0;
      dcount[i] = 0; viol[i] = 0;
      prev_sclk[i] = 1'b0; prev_copi[i] = 1'b0; prev_ncs[i] = 1'b1;
      addr[i] = '0; wdata[i] = '0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!ncs[i]) begin
        low_cnt[i]++;
        if (sclk[i] && !prev_sclk[i]) begin
          sh[i] = {sh[i][14:0], copi[i]};
          bits[i]++;
        end
      end else begin
        high_cnt[i]++;
      end
      if (!ncs[i] && prev_ncs[i]) begin
        last_high[i] = high_cnt[i];
        high_cnt[i] = 0;
      end
      if (ncs[i] && !prev_ncs[i]) begin
        if (bits[i] == 16) begin
          last_frame[i] = sh[i];
          last_low[i] = low_cnt[i];
          nframes[i]++;
        end else begin
          partial[i]++;
        end
        bits[i] = 0;
        low_cnt[i] = 0;
        high_cnt[i] = 1;
      end
      if (sclk[i] && copi[i] != prev_copi[i]) viol[i]++;
      if (sclk[i] && ncs[i]) viol[i]++;
      if (done[i]) dcount[i]++;
      prev_sclk[i] = sclk[i];
      prev_copi[i] = copi[i];
      prev_ncs[i] = ncs[i];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic int tdiv(input int i);
    return (i == 0) ? 4 : (i == 1) ? 2 : 7;
  endfunction

  task automatic run_frame(input int i, input logic [6:0] a,
                           input logic [7:0] w, output int n);
    addr[i] = a;
    wdata[i] = w;
    start[i] = 1'b1;
    n = 0;
    tick();
    start[i] = 1'b0;
    n = 1;
    while (!done[i] && n < 500) begin
      tick();
      n++;
    end
  endtask

  int n, d0, f0, p0, first_rise, k;
  int dn [3];
  logic [6:0] ra;
  logic [7:0] rw;

  initial begin
    tick(); tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_sclk", 32'(sclk[0]), 0);
    chk("rst_copi", 32'(copi[0]), 0);
    chk("rst_ncs", 32'(ncs[0]), 1);
    chk("rst_busy", 32'(busy[0]), 0);
    chk("rst_done", 32'(done[0]), 0);

    // Basic frame 0x04 <- 0xA5 at T=4
    addr[0] = 7'h04;
    wdata[0] = 8'hA5;
    start[0] = 1'b1;
    n = 0;
    tick();
    start[0] = 1'b0;
    addr[0] = 7'h7F;
    wdata[0] = 8'h00;
    n = 1;
    chk("a_ncs_fall", 32'(ncs[0]), 0);
    chk("a_busy_rise", 32'(busy[0]), 1);
    chk("a_copi_b15", 32'(copi[0]), 1);
    first_rise = -1;
    while (!done[0] && n < 500) begin
      tick();
      n++;
      if (sclk[0] && first_rise < 0) first_rise = n;
    end
    chk("a_first_rise", 32'(first_rise), 5);
    chk("a_done_lat", 32'(n), 137);
    chk("a_busy_done", 32'(busy[0]), 0);
    chk("a_frame", 32'(last_frame[0]), 32'h84A5);
    chk("a_ncs_low", 32'(last_low[0]), 132);
    tick();
    chk("a_done_width", 32'(done[0]), 0);

    // Start during an in-flight frame is ignored
    d0 = dcount[0];
    f0 = nframes[0];
    addr[0] = 7'h03;
    wdata[0] = 8'h3C;
    start[0] = 1'b1;
    n = 0;
    tick();
    start[0] = 1'b0;
    n = 1;
    while (!done[0] && n < 500) begin
      if (n == 50) begin
        addr[0] = 7'h01;
        start[0] = 1'b1;
      end else begin
        start[0] = 1'b0;
      end
      tick();
      n++;
    end
    start[0] = 1'b0;
    chk("b_done_lat", 32'(n), 137);
    repeat (200) tick();
    chk("b_done_cnt", 32'(dcount[0] - d0), 1);
    chk("b_frame_cnt", 32'(nframes[0] - f0), 1);
    chk("b_frame", 32'(last_frame[0]), 32'h833C);

    // Reset at cycle 40 of a frame
    d0 = dcount[0];
    f0 = nframes[0];
    p0 = partial[0];
    addr[0] = 7'h02;
    wdata[0] = 8'h55;
    start[0] = 1'b1;
    n = 0;
    tick();
    start[0] = 1'b0;
    n = 1;
    while (n < 40) begin
      tick();
      n++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("c_ncs", 32'(ncs[0]), 1);
    chk("c_sclk", 32'(sclk[0]), 0);
    chk("c_busy", 32'(busy[0]), 0);
    repeat (200) tick();
    chk("c_no_done", 32'(dcount[0] - d0), 0);
    chk("c_no_frame", 32'(nframes[0] - f0), 0);
    chk("c_partial", 32'(partial[0] - p0), 1);

    // Reset and start together: reset wins
    rst = 1'b1;
    start[0] = 1'b1;
    tick();
    rst = 1'b0;
    start[0] = 1'b0;
    chk("d_busy", 32'(busy[0]), 0);
    chk("d_ncs", 32'(ncs[0]), 1);
    tick();
    chk("d_busy2", 32'(busy[0]), 0);

    // start held high for three back-to-back frames at T=2
    d0 = dcount[1];
    f0 = nframes[1];
    addr[1] = 7'h10;
    wdata[1] = 8'h01;
    start[1] = 1'b1;
    n = 0;
    k = 0;
    dn[0] = 0; dn[1] = 0; dn[2] = 0;
    while (k < 3 && n < 400) begin
      tick();
      n++;
      if (done[1]) begin
        dn[k] = n;
        k++;
        if (k == 3) start[1] = 1'b0;
      end
    end
    start[1] = 1'b0;
    chk("e_done0", 32'(dn[0]), 69);
    chk("e_done1", 32'(dn[1]), 138);
    chk("e_done2", 32'(dn[2]), 207);
    tick();
    chk("e_done_width", 32'(done[1]), 0);
    chk("e_busy_end", 32'(busy[1]), 0);
    repeat (100) tick();
    chk("e_done_cnt", 32'(dcount[1] - d0), 3);
    chk("e_frames", 32'(nframes[1] - f0), 3);
    chk("e_frame", 32'(last_frame[1]), 32'h9001);
    chk("e_ncs_high", 32'(last_high[1]), 3);
    chk("e_ncs_low", 32'(last_low[1]), 66);

    // Random frames on every divider
    for (int i = 0; i < 3; i++) begin
      for (int f = 0; f < 30; f++) begin
        ra = 7'($urandom_range(0, 127));
        rw = 8'($urandom_range(0, 255));
        run_frame(i, ra, rw, n);
        chk("r_lat", 32'(n), 32'(1 + 34 * tdiv(i)));
        chk("r_frame", 32'(last_frame[i]), 32'({1'b1, ra, rw}));
        chk("r_ncs_low", 32'(last_low[i]), 32'(33 * tdiv(i)));
        tick();
      end
    end

    repeat (20) tick();
    for (int i = 0; i < 3; i++) begin
      chk("mode0_viol", 32'(viol[i]), 0);
    end
    chk("partial_u2", 32'(partial[1]), 0);
    chk("partial_u7", 32'(partial[2]), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
